// File: rtl/stream_matvec_accum_blocked_pkg.sv
// Shared types and arithmetic helpers for the blocked matrix-vector accumulator.
// Holds the FSM state encoding and the signed product/extend helper.
package stream_matvec_accum_blocked_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_DONE
  } state_t;

  // Widest operand / accumulator the helper supports; callers
  // sign-extend into and truncate out of these widths.
  localparam int MAX_D_W   = 16;
  localparam int MAX_ACC_W = 64;

  function automatic logic signed [MAX_ACC_W-1:0] prod_ext(
    input logic signed [MAX_D_W-1:0] a,
    input logic signed [MAX_D_W-1:0] b
  );
    logic signed [2*MAX_D_W-1:0] p;
    p = a * b;
    return MAX_ACC_W'(p);
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle: tdata/tvalid/tlast forward, tready back.
// Modports: axi_in (sink side), axi_out (source side).
interface axi_stream_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport axi_in  (input tdata, tvalid, tlast, output tready);
  modport axi_out (output tdata, tvalid, tlast, input tready);
endinterface

// File: rtl/stream_matvec_accum_blocked_psum_ram.sv
// Partial-sum store: DEPTH x W registers, async read, sync write.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module matvec_psum_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // No reset: block 0 always overwrites before any read is used.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_matvec_accum_blocked.sv
// Joins vector/matrix beat streams, accumulates per-row dot products
// across blocks and emits one ACC_W result per row (tlast on last row).
// Ports: clk, rst (sync, active-high), in_vec/in_mat (sinks), out_res
// (source), DIM1/BLOCKS/BLOCK_WIDTH (live dims), err_tlast when
// STREAM_MATVEC_TLAST_CHECK_EN is defined.
module stream_matvec_accum_blocked
  import stream_matvec_accum_blocked_pkg::*;
#(
  parameter int D_W          = 8,
  parameter int ACC_W        = 32,
  parameter int MATRIXSIZE_W = 24,
  parameter int PSUM_DEPTH   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_stream_if.axi_in            in_vec,
  axi_stream_if.axi_in            in_mat,
  axi_stream_if.axi_out           out_res,
  input  logic [MATRIXSIZE_W-1:0] DIM1,
  input  logic [MATRIXSIZE_W-1:0] BLOCKS,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTH
`ifdef STREAM_MATVEC_TLAST_CHECK_EN
  ,
  output logic                    err_tlast
`endif
);

  localparam int AW = $clog2(PSUM_DEPTH);
  localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

  state_t state_q, state_d;

  logic [MATRIXSIZE_W-1:0] elem_cntr_q, elem_cntr_d;
  logic [MATRIXSIZE_W-1:0] row_cntr_q, row_cntr_d;
  logic [MATRIXSIZE_W-1:0] block_cntr_q, block_cntr_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [ACC_W-1:0] prod, row_sum, base, total, psum_rd;
  logic signed [MAX_D_W-1:0] a_x, b_x;
  logic rdy, beat_hs, first_e, last_e, last_r, last_b;
  logic final_beat, row_end, psum_we;

  assign a_x = MAX_D_W'(signed'(in_vec.tdata[D_W-1:0]));
  assign b_x = MAX_D_W'(signed'(in_mat.tdata[D_W-1:0]));
  assign prod = ACC_W'(prod_ext(a_x, b_x));

  assign first_e = (elem_cntr_q == '0);
  assign last_e  = (elem_cntr_q == BLOCK_WIDTH - ONE);
  assign last_r  = (row_cntr_q == DIM1 - ONE);
  assign last_b  = (block_cntr_q == BLOCKS - ONE);
  assign final_beat = last_e & last_r & last_b;

  // Stall intake while a result is held and not being drained; gated
  // by rst so nothing is accepted in the reset cycle itself.
  assign rdy = ~rst & (state_q == ST_RUN)
             & in_vec.tvalid & in_mat.tvalid
             & ~(out_valid_q & ~out_res.tready);
  assign in_vec.tready = rdy;
  assign in_mat.tready = rdy;
  assign beat_hs = rdy;

  assign row_end = beat_hs & last_e;
  assign row_sum = (first_e ? '0 : acc_q) + prod;
  assign base    = (block_cntr_q == '0) ? '0 : psum_rd;
  assign total   = base + row_sum;
  assign psum_we = row_end & ~last_b;

  matvec_psum_ram #(
    .DEPTH(PSUM_DEPTH),
    .W    (ACC_W),
    .AW   (AW)
  ) u_psum (
    .clk  (clk),
    .we   (psum_we),
    .waddr(row_cntr_q[AW-1:0]),
    .wdata(total),
    .raddr(row_cntr_q[AW-1:0]),
    .rdata(psum_rd)
  );

  assign out_res.tvalid = out_valid_q & ~rst;
  assign out_res.tdata  = out_data_q;
  assign out_res.tlast  = out_last_q;

  always_comb begin
    elem_cntr_d  = elem_cntr_q;
    row_cntr_d   = row_cntr_q;
    block_cntr_d = block_cntr_q;
    acc_d        = acc_q;
    if (beat_hs) begin
      acc_d = row_sum;
      if (!last_e) begin
        elem_cntr_d = elem_cntr_q + ONE;
      end else begin
        elem_cntr_d = '0;
        if (!last_r) begin
          row_cntr_d = row_cntr_q + ONE;
        end else begin
          row_cntr_d   = '0;
          block_cntr_d = last_b ? '0 : block_cntr_q + ONE;
        end
      end
    end
  end

  // A reload in the same cycle as a drain wins and keeps valid high.
  always_comb begin
    out_valid_d = out_valid_q & ~out_res.tready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (row_end & last_b) begin
      out_valid_d = 1'b1;
      out_data_d  = total;
      out_last_d  = last_r;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   if (beat_hs & final_beat) state_d = ST_DONE;
      ST_DONE:  if (~out_valid_q | (out_res.tready & out_last_q))
                  state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      elem_cntr_q  <= '0;
      row_cntr_q   <= '0;
      block_cntr_q <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_cntr_q  <= elem_cntr_d;
      row_cntr_q   <= row_cntr_d;
      block_cntr_q <= block_cntr_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

`ifdef STREAM_MATVEC_TLAST_CHECK_EN
  logic err_tlast_q, err_tlast_d;

  always_comb begin
    err_tlast_d = err_tlast_q;
    if (beat_hs & ((in_vec.tlast != final_beat) |
                   (in_mat.tlast != final_beat)))
      err_tlast_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_tlast_q <= 1'b0;
    else     err_tlast_q <= err_tlast_d;
  end

  assign err_tlast = err_tlast_q;
`else
  // Input tlast carries no meaning here; job framing comes from the dims.
`endif

endmodule

// File: tb/tb_stream_matvec_accum_blocked.sv
// Directed bench for stream_matvec_accum_blocked: hand-computed results
// for several shapes, backpressure, mid-job reset and optional tlast check.
module tb_stream_matvec_accum_blocked;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] dim1, blocks, bwidth;
`ifdef STREAM_MATVEC_TLAST_CHECK_EN
  logic err_tlast;
`endif

  always #5 clk = ~clk;

  axi_stream_if #(.DATA_W(8))  vec_if ();
  axi_stream_if #(.DATA_W(8))  mat_if ();
  axi_stream_if #(.DATA_W(32)) out_if ();

  stream_matvec_accum_blocked dut (
    .clk        (clk),
    .rst        (rst),
    .in_vec     (vec_if),
    .in_mat     (mat_if),
    .out_res    (out_if),
    .DIM1       (dim1),
    .BLOCKS     (blocks),
    .BLOCK_WIDTH(bwidth)
`ifdef STREAM_MATVEC_TLAST_CHECK_EN
    ,
    .err_tlast  (err_tlast)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int vb[$];
  int mb[$];
  int eb[$];
  int last_hs_cyc;
  int first_out_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    vec_if.tvalid = 1'b0;
    vec_if.tdata  = '0;
    vec_if.tlast  = 1'b0;
    mat_if.tvalid = 1'b0;
    mat_if.tdata  = '0;
    mat_if.tlast  = 1'b0;
  endtask

  task automatic setup_s1();
    dim1 = 24'd2; blocks = 24'd2; bwidth = 24'd2;
    vb = '{1, 2, 1, 2, 3, 4, 3, 4};
    mb = '{1, 1, 2, 0, 1, 1, -1, 3};
    eb = '{10, 11};
  endtask

  // Drives nb beats on each stream (independently toggled when bp),
  // expects ne results in order; tl_bad flips vec tlast on that beat.
  task automatic run_job(input int nb, input int ne, input bit bp,
                         input int tl_bad);
    int vi, mi, oi, cyc;
    vi = 0; mi = 0; oi = 0; cyc = 0;
    last_hs_cyc = -1;
    first_out_cyc = -1;
    while ((vi < nb || mi < nb || oi < ne) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      vec_if.tvalid = (vi < nb) && (!bp || $urandom_range(0, 1) == 1);
      vec_if.tdata  = 8'(vb[(vi < nb) ? vi : 0]);
      vec_if.tlast  = (vi == vb.size() - 1) ^ (vi == tl_bad);
      mat_if.tvalid = (mi < nb) && (!bp || $urandom_range(0, 1) == 1);
      mat_if.tdata  = 8'(mb[(mi < nb) ? mi : 0]);
      mat_if.tlast  = (mi == mb.size() - 1);
      out_if.tready = !bp || ($urandom_range(0, 99) >= 30);
      #1;
      chk("rdy_join",
          vec_if.tready & ~(vec_if.tvalid & mat_if.tvalid), 1'b0);
      chk("rdy_eq", vec_if.tready, mat_if.tready);
      if (vec_if.tvalid && vec_if.tready) begin
        vi++;
        if (vi == nb) last_hs_cyc = cyc;
      end
      if (mat_if.tvalid && mat_if.tready) mi++;
      if (out_if.tvalid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_if.tvalid && out_if.tready) begin
        chk("res_in_range", (oi < ne), 1'b1);
        if (oi < ne) begin
          chk("res_data", out_if.tdata, 32'(eb[oi]));
          chk("res_last", out_if.tlast, (oi == ne - 1));
        end
        oi++;
      end
    end
    @(negedge clk);
    idle_inputs();
    out_if.tready = 1'b1;
    chk("beats_vec", vi, nb);
    chk("beats_mat", mi, nb);
    chk("results", oi, ne);
    repeat (3) @(negedge clk);
    chk("no_extra", out_if.tvalid, 1'b0);
  endtask

  initial begin
    idle_inputs();
    out_if.tready = 1'b1;
    dim1 = 24'd2; blocks = 24'd2; bwidth = 24'd2;
    vec_if.tvalid = 1'b1;
    mat_if.tvalid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", out_if.tvalid, 1'b0);
    chk("rst_tlast", out_if.tlast, 1'b0);
    chk("rst_tdata", out_if.tdata, 32'd0);
    chk("rst_vec_rdy", vec_if.tready, 1'b0);
    chk("rst_mat_rdy", mat_if.tready, 1'b0);
`ifdef STREAM_MATVEC_TLAST_CHECK_EN
    chk("rst_err", err_tlast, 1'b0);
`endif
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);

    setup_s1();
    run_job(8, 2, 1'b0, -1);

    dim1 = 24'd1; blocks = 24'd1; bwidth = 24'd4;
    vb = '{-128, -128, 127, 1};
    mb = '{-128, 1, 1, -1};
    eb = '{16382};
    run_job(4, 1, 1'b0, -1);
    chk("latency", first_out_cyc - last_hs_cyc, 32'd1);

    setup_s1();
    run_job(8, 2, 1'b1, -1);
    run_job(8, 2, 1'b1, -1);

    dim1 = 24'd3; blocks = 24'd3; bwidth = 24'd1;
    vb = '{2, 2, 2, 3, 3, 3, 4, 4, 4};
    mb = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    eb = '{9, 9, 9};
    run_job(9, 3, 1'b0, -1);

    setup_s1();
    run_job(3, 0, 1'b0, -1);
    @(negedge clk);
    rst = 1'b1;
    vec_if.tvalid = 1'b1;
    mat_if.tvalid = 1'b1;
    #1;
    chk("mid_rst_rdy0", vec_if.tready, 1'b0);
    chk("mid_rst_vld0", out_if.tvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_rdy1", vec_if.tready, 1'b0);
    chk("mid_rst_vld1", out_if.tvalid, 1'b0);
    idle_inputs();
    run_job(8, 2, 1'b0, -1);

`ifdef STREAM_MATVEC_TLAST_CHECK_EN
    chk("err_clean", err_tlast, 1'b0);
    setup_s1();
    run_job(8, 2, 1'b0, 4);
    chk("err_set", err_tlast, 1'b1);
    repeat (4) @(negedge clk);
    chk("err_held", err_tlast, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
